// File: rtl/siggen_scheduler.sv
// Sequencer that time-shares one synchronous sine ROM between two phase
// accumulators and presents each fetched sample pair on a valid/ready port.
//
//   state | meaning
//   IDLE  | waiting for start; done pulses here after a run ends
//   ADDR0 | ROM address = acc0
//   ADDR1 | ROM address = acc1 + offset1; ch0 sample captured at end
//   CAP1  | ch1 sample captured at end
//   HOLD  | pair presented; advance on handshake
module siggen_scheduler #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int L_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [L_WIDTH-1:0] burst_len,
    input  logic [A_WIDTH-1:0] incr0,
    input  logic [A_WIDTH-1:0] incr1,
    input  logic [A_WIDTH-1:0] offset1,
    output logic [A_WIDTH-1:0] rom_addr,
    input  logic [D_WIDTH-1:0] rom_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] dout0,
    output logic [D_WIDTH-1:0] dout1,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, CAP1, HOLD} state_t;

    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] acc0, acc1;
    logic [L_WIDTH-1:0] count, count_inc;
    logic               stop_flag;
    logic [L_WIDTH-1:0] cfg_len;
    logic [A_WIDTH-1:0] cfg_incr0, cfg_incr1, cfg_offset1;
    logic               fire, end_run;

    assign count_inc = count + L_WIDTH'(1);
    assign fire      = (state == HOLD) && out_ready;
    // A zero burst length never matches, so continuous runs end only on stop.
    assign end_run   = ((cfg_len != '0) && (count_inc == cfg_len)) || stop_flag;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rom_addr  = acc0;
        case (state)
            IDLE:  if (start) state_nxt = ADDR0;
            ADDR0: state_nxt = ADDR1;
            ADDR1: begin
                rom_addr  = acc1 + cfg_offset1;
                state_nxt = CAP1;
            end
            CAP1:  state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = end_run ? IDLE : ADDR0;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc0        <= '0;
            acc1        <= '0;
            count       <= '0;
            stop_flag   <= 1'b0;
            cfg_len     <= '0;
            cfg_incr0   <= '0;
            cfg_incr1   <= '0;
            cfg_offset1 <= '0;
            dout0       <= '0;
            dout1       <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    cfg_len     <= burst_len;
                    cfg_incr0   <= incr0;
                    cfg_incr1   <= incr1;
                    cfg_offset1 <= offset1;
                    acc0        <= '0;
                    acc1        <= '0;
                    count       <= '0;
                    stop_flag   <= 1'b0;
                end
            end else begin
                if (stop) stop_flag <= 1'b1;
                if (state == ADDR1) dout0 <= rom_dout;
                if (state == CAP1)  dout1 <= rom_dout;
                if (fire) begin
                    acc0  <= acc0 + cfg_incr0;
                    acc1  <= acc1 + cfg_incr1;
                    count <= count_inc;
                    if (end_run) done <= 1'b1;
                end
            end
        end
    end

endmodule
